div_seq_nbits: RTL
==================

Name: div_seq_nbits

Overview:
- Multi-cycle N-bit integer divider.
- Covers the operations the single-cycle N-bit ALU cannot do in one pass: it undoes multiplication, producing a quotient and a remainder.
- Sits beside the ALU in the execute stage and is driven by the control unit through a start/done handshake.
- Supports signed and unsigned operands using a restoring shift-subtract algorithm, one quotient bit per clock.

Parameters:
- N, 8, operand/result width in bits (N >= 2).

Ports:
- clk_i  input  1  system clock, all state updates on rising edge
- rst_i  input  1  synchronous reset, active-high
- start_i  input  1  request a division; sampled only in IDLE
- signed_i  input  1  1 = two's-complement operands, 0 = unsigned; captured with start_i
- dividend_i  input  N  dividend; captured with start_i
- divisor_i  input  N  divisor; captured with start_i
- busy_o  output  1  high while an operation is in progress
- done_o  output  1  one-cycle pulse when results are valid
- quotient_o  output  N  quotient; held until the next accepted start
- remainder_o  output  N  remainder; held until the next accepted start
- div_zero_o  output  1  set with done_o when divisor was 0; held like the results

Behaviour:
- Reset (rst_i=1 at a clock edge, any state):
  - state <- IDLE; busy_o, done_o, div_zero_o <- 0; quotient_o, remainder_o <- 0.
  - Reset wins over start_i in the same cycle.
  - Reset mid-operation aborts it with no done_o pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start_i=1:
  - Capture operands.
  - If signed_i=1, store the magnitudes, and record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Clear the partial remainder (N+1 bits) and the step counter.
  - busy_o <- 1.
  - Next state: FIX if the divisor is 0, else CALC.
- IDLE, start_i=0: no change; done_o=0.
- CALC, one step per cycle, exactly N cycles:
  - Shift {partial remainder, dividend register} left by 1.
  - Trial subtract the divisor magnitude (N+1-bit arithmetic).
  - If the result is non-negative, keep it and shift a 1 into the quotient; else restore and shift a 0.
  - Counter increments; after step N, go to FIX.
- FIX (1 cycle):
  - Divisor zero: quotient_o <- all ones; remainder_o <- original dividend; div_zero_o <- 1.
  - Otherwise: quotient_o <- quotient, negated if signed_i and sign_q; remainder_o <- remainder, negated if signed_i and sign_r; div_zero_o <- 0.
  - Next state: DONE.
- DONE (1 cycle): done_o=1, busy_o=0; next state IDLE. start_i here is ignored.
- Latency, start_i sampled at edge k:
  - busy_o high after edge k until edge k+N+2.
  - done_o high in the cycle after edge k+N+2.
  - Total N+2 cycles of busy; a divide-by-zero takes 2 cycles.
- start_i asserted while busy or in DONE is ignored; it does not queue.
- Operand inputs may change freely after capture.
- Signed overflow (most-negative / -1): quotient = most-negative value, remainder = 0. This falls out naturally from magnitude arithmetic and needs no special case.
- The sign of the remainder always follows the dividend (truncating division).
- Outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Unsigned 100/7, N=8, start at edge 0 -> busy_o for 10 cycles, done_o pulse once, quotient_o=14 (0x0E), remainder_o=2, div_zero_o=0.
- Signed -7/2 (0xF9, 0x02) -> quotient_o=0xFD (-3), remainder_o=0xFF (-1); signed 7/-2 -> 0xFD, 0x01.
- Divide by zero, 0x2A/0 unsigned -> done_o 2 cycles after start, quotient_o=0xFF, remainder_o=0x2A, div_zero_o=1.
- Signed overflow 0x80/0xFF -> quotient_o=0x80, remainder_o=0x00; unsigned 0xFF/0x01 -> 0xFF, 0x00.
- Reset at cycle 4 of an active division -> next cycle busy_o=0, done_o never pulses, all outputs 0. A following start with 9/3 yields 3, 0.
- start_i held high continuously with new operands -> only back-to-back operations, each separated by DONE; a start during busy does not disturb the current result.

Source files
------------

// File: rtl/div_seq_nbits.sv
// ---------------------------------------------------------------------------
// div_seq_nbits
//
// Multi-cycle N-bit integer divider (restoring shift-subtract, one quotient
// bit per clock). Handles signed (two's-complement, truncating) and unsigned
// operands. Sits beside the single-cycle ALU in the execute stage and is
// driven by the control unit through a start/done handshake.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        synchronous reset, active-high
//   start_i      request a division (sampled only in IDLE)
//   signed_i     1 = two's-complement operands, captured with start_i
//   dividend_i   N-bit dividend, captured with start_i
//   divisor_i    N-bit divisor, captured with start_i
//   busy_o       high while an operation is in progress
//   done_o       one-cycle pulse when results are valid
//   quotient_o   quotient, held until rewritten by the next operation
//   remainder_o  remainder, held like the quotient
//   div_zero_o   divisor was zero, held like the results
//
// State table
//   state  | meaning
//   IDLE   | waiting for start_i, results held
//   CALC   | N shift/trial-subtract steps, one quotient bit per cycle
//   FIX    | sign correction / divide-by-zero result, outputs written
//   DONE   | done_o raised, busy_o dropped, back to IDLE
// ---------------------------------------------------------------------------
module div_seq_nbits #(
   parameter int N = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic         signed_i,
   input  logic [N-1:0] dividend_i,
   input  logic [N-1:0] divisor_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [N-1:0] quotient_o,
   output logic [N-1:0] remainder_o,
   output logic         div_zero_o
);

   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [N:0]   r_rem;
   logic [N-1:0] r_dvd;
   logic [N-1:0] r_dvs;
   logic [N-1:0] r_dvd_orig;
   logic [CW-1:0] r_cnt;
   logic         r_sign_q;
   logic         r_sign_r;
   logic         r_dz;
   logic         r_busy;
   logic         r_done;
   logic [N-1:0] r_quo_out;
   logic [N-1:0] r_rem_out;
   logic         r_dz_out;

   logic         w_dvd_neg;
   logic         w_dvs_neg;
   logic [N-1:0] w_dvd_mag;
   logic [N-1:0] w_dvs_mag;
   logic         w_dvs_zero;
   logic         w_last;
   logic [N+1:0] w_shift;
   logic [N+1:0] w_trial;
   logic         w_fits;
   logic [N-1:0] w_quo_fix;
   logic [N-1:0] w_rem_fix;

   // Operand magnitudes. The most-negative value maps onto itself, which
   // read as unsigned is exactly its magnitude, so overflow needs no case.
   assign w_dvd_neg  = signed_i & dividend_i[N-1];
   assign w_dvs_neg  = signed_i & divisor_i[N-1];
   assign w_dvd_mag  = w_dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
   assign w_dvs_mag  = w_dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
   assign w_dvs_zero = (divisor_i == '0);

   assign w_last = (r_cnt == CW'(N - 1));

   // The shifted partial remainder can reach 2^(N+1)-1, so the trial
   // subtraction carries one extra bit whose top bit is the borrow.
   assign w_shift = {r_rem, r_dvd[N-1]};
   assign w_trial = w_shift - {2'b00, r_dvs};
   assign w_fits  = ~w_trial[N+1];

   assign w_quo_fix = r_sign_q ? (~r_dvd + 1'b1) : r_dvd;
   assign w_rem_fix = r_sign_r ? (~r_rem[N-1:0] + 1'b1) : r_rem[N-1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_state_nxt = w_dvs_zero ? S_FIX : S_CALC;
            end
         end
         S_CALC: begin
            if (w_last) begin
               w_state_nxt = S_FIX;
            end
         end
         S_FIX:   w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rem      <= '0;
         r_dvd      <= '0;
         r_dvs      <= '0;
         r_dvd_orig <= '0;
         r_cnt      <= '0;
         r_sign_q   <= 1'b0;
         r_sign_r   <= 1'b0;
         r_dz       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_quo_out  <= '0;
         r_rem_out  <= '0;
         r_dz_out   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_dvd      <= w_dvd_mag;
                  r_dvs      <= w_dvs_mag;
                  r_dvd_orig <= dividend_i;
                  r_sign_q   <= w_dvd_neg ^ w_dvs_neg;
                  r_sign_r   <= w_dvd_neg;
                  r_dz       <= w_dvs_zero;
                  r_rem      <= '0;
                  r_cnt      <= '0;
                  r_busy     <= 1'b1;
               end
            end
            S_CALC: begin
               // The dividend register doubles as the quotient shift register.
               r_rem <= w_fits ? w_trial[N:0] : w_shift[N:0];
               r_dvd <= {r_dvd[N-2:0], w_fits};
               r_cnt <= r_cnt + CW'(1);
            end
            S_FIX: begin
               if (r_dz) begin
                  r_quo_out <= '1;
                  r_rem_out <= r_dvd_orig;
                  r_dz_out  <= 1'b1;
               end else begin
                  r_quo_out <= w_quo_fix;
                  r_rem_out <= w_rem_fix;
                  r_dz_out  <= 1'b0;
               end
            end
            S_DONE: begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o      = r_busy;
   assign done_o      = r_done;
   assign quotient_o  = r_quo_out;
   assign remainder_o = r_rem_out;
   assign div_zero_o  = r_dz_out;

endmodule
